// File: rtl/light_counter_pkg.sv
// rtl/light_counter_pkg.sv - shared constants, FSM state types and helpers for the light counter
package light_counter_pkg;

  // Register index (addr[3:2])
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_COUNT   = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_DOWN   = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_WRAP   = 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [31:0] PERIOD_RST  = 32'h0;
  localparam logic [31:0] COUNT_RST   = 32'h0;
  localparam logic [31:0] SCRATCH_RST = 32'h0;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Merge write data into an existing word, one byte lane per strobe bit
  function automatic logic [31:0] apply_strb(input logic [31:0] old_value,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] result;
    result = old_value;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) result[i*8 +: 8] = data[i*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/light_counter_axil_slave_if.sv
// rtl/light_counter_axil_slave_if.sv - AXI4-Lite signal bundle with master and slave views
interface light_counter_axil_slave_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/light_counter_core.sv
// rtl/light_counter_core.sv - prescaled up/down 32-bit counter with clear, load and wrap pulse
module light_counter_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        down,
  input  logic [31:0] period,
  output logic [31:0] count,
  output logic        wrap
);
  import light_counter_pkg::*;

  logic [31:0] prescale;
  logic        tick;

  assign tick = enable && (prescale == period);
  // A wrap only counts if the step actually happens (clear/load override the tick)
  assign wrap = tick && !clear && !load && (down ? (count == 32'h0) : (count == 32'hFFFF_FFFF));

  // Prescaler and counter; clear beats load, load beats a same-cycle tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= 32'h0;
      count    <= COUNT_RST;
    end else if (clear) begin
      prescale <= 32'h0;
      count    <= 32'h0;
    end else if (load) begin
      prescale <= 32'h0;
      count    <= load_value;
    end else if (enable) begin
      if (tick) begin
        prescale <= 32'h0;
        count    <= down ? count - 32'd1 : count + 32'd1;
      end else begin
        prescale <= prescale + 32'd1;
      end
    end
  end

endmodule

// File: rtl/light_counter_axil_slave.sv
// rtl/light_counter_axil_slave.sv - AXI4-Lite register slave for the light counter; LIGHT_COUNTER_IRQ_EN adds wrap flag and irq
module light_counter_axil_slave #(
  parameter int ADDR_W = 4,
  parameter int LED_W  = 8
) (
  input  logic             ACLK,
  input  logic             ARESET,
  light_counter_axil_slave_if.slave s_axi,
  output logic [LED_W-1:0] leds
`ifdef LIGHT_COUNTER_IRQ_EN
  ,
  output logic             irq
`endif
);
  import light_counter_pkg::*;

  logic        live;
  wr_state_t   wr_state, wr_next;
  rd_state_t   rd_state, rd_next;
  logic        aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_hs, w_hs, ar_hs;
  logic [1:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_commit;
  logic        ctrl_enable, ctrl_down;
  logic [31:0] period_q, scratch_q, count, ctrl_read, rd_value, rdata_q;
  logic        core_clear, core_load, core_wrap;
  logic        unused_ok;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;

  // A channel captured this cycle is used directly so the commit lands on the same edge
  assign wr_idx    = aw_held ? aw_addr_q[3:2] : s_axi.awaddr[3:2];
  assign wr_data   = w_held ? wdata_q : s_axi.wdata;
  assign wr_strb   = w_held ? wstrb_q : s_axi.wstrb;
  assign wr_commit = (wr_state == W_IDLE) && (wr_next == W_RESP);

  // Readies stay low until the first clock edge after reset release
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) live <= 1'b0;
    else        live <= 1'b1;
  end

  // FSM state registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    wr_next = wr_state;
    rd_next = rd_state;
    case (wr_state)
      W_IDLE: if ((aw_held || aw_hs) && (w_held || w_hs)) wr_next = W_RESP;
      W_RESP: if (s_axi.bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
    case (rd_state)
      R_IDLE: if (ar_hs) rd_next = R_DATA;
      R_DATA: if (s_axi.rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    s_axi.awready = live && (wr_state == W_IDLE) && !aw_held;
    s_axi.wready  = live && (wr_state == W_IDLE) && !w_held;
    s_axi.bvalid  = (wr_state == W_RESP);
    s_axi.bresp   = RESP_OKAY;
    s_axi.arready = live && (rd_state == R_IDLE);
    s_axi.rvalid  = (rd_state == R_DATA);
    s_axi.rresp   = RESP_OKAY;
    s_axi.rdata   = rdata_q;
  end

  // Hold AW and W independently until both have arrived
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi.awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (wr_commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Register file writes (COUNT lives in the core)
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_enable <= 1'b0;
      ctrl_down   <= 1'b0;
      period_q    <= PERIOD_RST;
      scratch_q   <= SCRATCH_RST;
    end else if (wr_commit) begin
      case (wr_idx)
        REG_CTRL: if (wr_strb[0]) begin
          ctrl_enable <= wr_data[CTRL_ENABLE];
          ctrl_down   <= wr_data[CTRL_DOWN];
        end
        REG_PERIOD:  period_q  <= apply_strb(period_q, wr_data, wr_strb);
        REG_SCRATCH: scratch_q <= apply_strb(scratch_q, wr_data, wr_strb);
        default: ;
      endcase
    end
  end

  assign core_clear = wr_commit && (wr_idx == REG_CTRL) && wr_strb[0] && wr_data[CTRL_CLEAR];
  assign core_load  = wr_commit && (wr_idx == REG_COUNT);

  light_counter_core u_core (
    .clk        (ACLK),
    .rst        (ARESET),
    .enable     (ctrl_enable),
    .clear      (core_clear),
    .load       (core_load),
    .load_value (apply_strb(count, wr_data, wr_strb)),
    .down       (ctrl_down),
    .period     (period_q),
    .count      (count),
    .wrap       (core_wrap)
  );

  assign leds = count[LED_W-1:0];

`ifdef LIGHT_COUNTER_IRQ_EN
  logic ctrl_irq_en, ctrl_wrap, irq_en_next, wrap_next;

  // Wrap flag is W1C; a wrap in the same cycle as the clear keeps it set
  always_comb begin
    irq_en_next = ctrl_irq_en;
    wrap_next   = ctrl_wrap;
    if (wr_commit && (wr_idx == REG_CTRL)) begin
      if (wr_strb[0]) irq_en_next = wr_data[CTRL_IRQ_EN];
      if (wr_strb[1] && wr_data[CTRL_WRAP]) wrap_next = 1'b0;
    end
    if (core_wrap) wrap_next = 1'b1;
  end

  // Interrupt state and registered irq output
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ctrl_irq_en <= 1'b0;
      ctrl_wrap   <= 1'b0;
      irq         <= 1'b0;
    end else begin
      ctrl_irq_en <= irq_en_next;
      ctrl_wrap   <= wrap_next;
      irq         <= irq_en_next && wrap_next;
    end
  end

  assign ctrl_read = {23'h0, ctrl_wrap, 4'h0, ctrl_irq_en, ctrl_down, 1'b0, ctrl_enable};
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0], aw_addr_q[1:0]};
`else
  assign ctrl_read = {28'h0, ctrl_down, 1'b0, ctrl_enable};
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0], aw_addr_q[1:0], core_wrap};
`endif

  // Read mux on the registered values, so a same-cycle write is not yet visible
  always_comb begin
    rd_value = 32'h0;
    case (s_axi.araddr[3:2])
      REG_CTRL:   rd_value = ctrl_read;
      REG_PERIOD: rd_value = period_q;
      REG_COUNT:  rd_value = count;
      default:    rd_value = scratch_q;
    endcase
  end

  // Capture read data on the AR handshake; held while rvalid waits for rready
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)     rdata_q <= 32'h0;
    else if (ar_hs) rdata_q <= rd_value;
  end

endmodule
